// File: rtl/pong_input_ctrl.sv
// pong_input_ctrl: synchronises and conditions the five board buttons into paddle directions and a gated start pulse.
// Define PONG_INPUT_DEBOUNCE_EN to build the debounce counters; without it the synchronised level feeds the encoder directly.

module pong_input_btn #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level
);

  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
    end
  end

`ifdef PONG_INPUT_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             db;
  logic [CNT_W-1:0] cnt;

  // Any return of s2 to the held state restarts the count, so only an
  // unbroken run of DEBOUNCE_CYCLES differing samples flips db.
  always_ff @(posedge clk) begin
    if (reset) begin
      db  <= 1'b0;
      cnt <= '0;
    end else if (s2 == db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      db  <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign level = db;
`else
  // Counter sizing has no meaning without the debounce stage.
  localparam int unused_cfg = DEBOUNCE_CYCLES + CNT_W;

  assign level = s2;
`endif

endmodule

module pong_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_left_up,
  input  logic       btn_left_down,
  input  logic       btn_right_up,
  input  logic       btn_right_down,
  input  logic       btn_start,
  input  logic       game_running,
  output logic [1:0] player_left_input,
  output logic [1:0] player_right_input,
  output logic       start_game
);

  localparam int NUM_BTN     = 5;
  localparam int BTN_L_UP    = 0;
  localparam int BTN_L_DOWN  = 1;
  localparam int BTN_R_UP    = 2;
  localparam int BTN_R_DOWN  = 3;
  localparam int BTN_START   = 4;

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] level;
  logic               db_start_d;
  logic               start_edge;
  logic [1:0]         left_dir;
  logic [1:0]         right_dir;

  assign raw = {btn_start, btn_right_down, btn_right_up, btn_left_down, btn_left_up};

  genvar i;
  generate
    for (i = 0; i < NUM_BTN; i++) begin : g_btn
      pong_input_btn #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_btn (
        .clk   (clk),
        .reset (reset),
        .pin   (raw[i]),
        .level (level[i])
      );
    end
  endgenerate

  // Opposing buttons cancel, so 2'b11 can never reach the game logic.
  function automatic logic [1:0] encode_dir(input logic up, input logic down);
    return {up & ~down, down & ~up};
  endfunction

  assign left_dir   = encode_dir(level[BTN_L_UP], level[BTN_L_DOWN]);
  assign right_dir  = encode_dir(level[BTN_R_UP], level[BTN_R_DOWN]);
  assign start_edge = level[BTN_START] & ~db_start_d;

  // A press during a running game is dropped rather than remembered.
  always_ff @(posedge clk) begin
    if (reset) begin
      player_left_input  <= 2'b00;
      player_right_input <= 2'b00;
      start_game         <= 1'b0;
      db_start_d         <= 1'b0;
    end else begin
      player_left_input  <= left_dir;
      player_right_input <= right_dir;
      start_game         <= start_edge & ~game_running;
      db_start_d         <= level[BTN_START];
    end
  end

endmodule

// File: tb/tb_pong_input_ctrl.sv
// tb_pong_input_ctrl: table vectors plus hand sequences, every cycle checked against a run-length button model.
// Timing expectations follow whether PONG_INPUT_DEBOUNCE_EN is defined for the build.

module tb_pong_input_ctrl;

  localparam int DB = 4;
`ifdef PONG_INPUT_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
  localparam int FILT  = DB;
  localparam int LAT   = DB + 2;
`else
  localparam bit DB_EN = 1'b0;
  localparam int FILT  = 1;
  localparam int LAT   = 2;
`endif
  localparam int SETTLE = FILT + LAT + 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] btn = 5'b0;
  logic       game_running = 1'b0;
  logic [1:0] left;
  logic [1:0] right;
  logic       start;

  pong_input_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (20)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .btn_left_up        (btn[0]),
    .btn_left_down      (btn[1]),
    .btn_right_up       (btn[2]),
    .btn_right_down     (btn[3]),
    .btn_start          (btn[4]),
    .game_running       (game_running),
    .player_left_input  (left),
    .player_right_input (right),
    .start_game         (start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_q[$];
  logic [7:0] hist [5];
  logic [4:0] mdb = 5'b0;
  logic       mprev = 1'b0;

  logic [1:0] obs_left;
  logic [1:0] obs_right;
  int         pulses;
  int         run_len;
  int         max_run;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] dir(input logic up, input logic dn);
    if (up && !dn) return 2'b10;
    if (dn && !up) return 2'b01;
    return 2'b00;
  endfunction

  // Expected outputs for the coming edge. hist[b][k] is the pin level sampled k+1 edges ago;
  // a debounced level flips once the last FILT samples seen by s2 all disagree with it.
  task automatic model_push();
    logic [4:0] seen;
    logic [4:0] e;
    logic       flip;
    if (reset) begin
      e = 5'b0;
      for (int b = 0; b < 5; b++) hist[b] = 8'b0;
      mdb   = 5'b0;
      mprev = 1'b0;
    end else begin
      for (int b = 0; b < 5; b++) seen[b] = DB_EN ? mdb[b] : hist[b][1];
      e = {dir(seen[0], seen[1]), dir(seen[2], seen[3]), seen[4] & ~mprev & ~game_running};
      mprev = seen[4];
      if (DB_EN) begin
        for (int b = 0; b < 5; b++) begin
          flip = 1'b1;
          for (int k = 1; k <= FILT; k++) if (hist[b][k] == mdb[b]) flip = 1'b0;
          if (flip) mdb[b] = ~mdb[b];
        end
      end
      for (int b = 0; b < 5; b++) hist[b] = {hist[b][6:0], btn[b]};
    end
    exp_q.push_back(e);
  endtask

  task automatic step();
    logic [4:0] e;
    model_push();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("sb_left", left, e[4:3]);
      check("sb_right", right, e[2:1]);
      check("sb_start", start, e[0]);
    end
    if (left != 2'b00) obs_left = left;
    if (right != 2'b00) obs_right = right;
    if (start) begin
      pulses++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  endtask

  task automatic clear_obs();
    obs_left  = 2'b00;
    obs_right = 2'b00;
    pulses    = 0;
    run_len   = 0;
    max_run   = 0;
  endtask

  typedef struct {
    string      name;
    logic [4:0] pins;
    int         len;
    logic       gr;
    logic [1:0] exp_left;
    logic [1:0] exp_right;
    int         exp_pulses;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;

    vecs[0] = '{"left_up",      5'b00001, 10, 1'b0, 2'b10, 2'b00, 0};
    vecs[1] = '{"left_down",    5'b00010, 10, 1'b0, 2'b01, 2'b00, 0};
    vecs[2] = '{"right_glitch", 5'b01000,  3, 1'b0, 2'b00, (3 >= FILT) ? 2'b01 : 2'b00, 0};
    vecs[3] = '{"right_exact",  5'b01000,  4, 1'b0, 2'b00, 2'b01, 0};
    vecs[4] = '{"right_both",   5'b01100, 10, 1'b0, 2'b00, 2'b00, 0};
    vecs[5] = '{"left_both",    5'b00011, 10, 1'b0, 2'b00, 2'b00, 0};
    vecs[6] = '{"start_idle",   5'b10000, 12, 1'b0, 2'b00, 2'b00, 1};
    vecs[7] = '{"start_busy",   5'b10000, 12, 1'b1, 2'b00, 2'b00, 0};
    vecs[8] = '{"start_blip",   5'b10000,  1, 1'b0, 2'b00, 2'b00, (FILT == 1) ? 1 : 0};
    vecs[9] = '{"right_up",     5'b00100, 10, 1'b0, 2'b00, 2'b10, 0};

    // Reset with every button held: quiet during reset, then one start pulse.
    clear_obs();
    btn = 5'b11111;
    reset = 1'b1;
    repeat (2) step();
    check("reset_left", left, 2'b00);
    check("reset_right", right, 2'b00);
    check("reset_start", start, 1'b0);
    reset = 1'b0;
    repeat (SETTLE) step();
    check("held_reset_pulses", pulses, 1);
    check("held_reset_left", obs_left, 2'b00);
    btn = 5'b0;
    repeat (SETTLE) step();

    for (int v = 0; v < NV; v++) begin
      clear_obs();
      game_running = vecs[v].gr;
      btn = vecs[v].pins;
      repeat (vecs[v].len) step();
      btn = 5'b0;
      repeat (SETTLE) step();
      check({vecs[v].name, "_left"}, obs_left, vecs[v].exp_left);
      check({vecs[v].name, "_right"}, obs_right, vecs[v].exp_right);
      check({vecs[v].name, "_pulses"}, pulses, vecs[v].exp_pulses);
      game_running = 1'b0;
      repeat ($urandom_range(0, 3)) step();
    end

    // Press and release latency measured from the sampling edge.
    btn = 5'b00001;
    d = -1;
    for (int i = 0; i < 40 && d < 0; i++) begin
      step();
      if (left == 2'b10) d = i;
    end
    check("press_latency", d, LAT);
    repeat (3) step();
    btn = 5'b0;
    d = -1;
    for (int i = 0; i < 40 && d < 0; i++) begin
      step();
      if (left == 2'b00) d = i;
    end
    check("release_latency", d, LAT);
    repeat (SETTLE) step();

    // Held start: exactly one single-cycle pulse over 100 cycles.
    clear_obs();
    btn = 5'b10000;
    repeat (100) step();
    check("hold_pulses", pulses, 1);
    check("hold_pulse_width", max_run, 1);
    btn = 5'b0;
    repeat (SETTLE) step();

    // Edge during a running game is discarded, not replayed when the game ends.
    clear_obs();
    game_running = 1'b1;
    btn = 5'b10000;
    repeat (LAT + 3) step();
    game_running = 1'b0;
    repeat (20) step();
    check("busy_then_idle_pulses", pulses, 0);
    btn = 5'b0;
    repeat (SETTLE) step();

    // Reset mid-debounce restarts the press from the first post-reset edge.
    btn = 5'b00100;
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    d = -1;
    for (int i = 0; i < 40 && d < 0; i++) begin
      step();
      if (right == 2'b10) d = i;
    end
    check("reset_mid_latency", d, LAT);
    btn = 5'b0;
    repeat (SETTLE) step();

    // Random pin patterns, busy flag and occasional resets.
    for (int i = 0; i < 60; i++) begin
      btn = 5'($urandom_range(0, 31));
      game_running = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 19) == 0);
      repeat ($urandom_range(1, FILT + 3)) step();
      reset = 1'b0;
    end
    btn = 5'b0;
    game_running = 1'b0;
    repeat (SETTLE) step();

    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
